display_char_buffer: RTL

Character frame store directly downstream of the display instruction dispatcher. It accepts `(position, char_code)` write strobes, queues them in a small FIFO, and commits them to an 80x30 single-port character RAM. It also serves a read port for the scanout renderer, which has priority on the RAM. An optional post-reset sweep fills the screen with spaces.

---
 rtl/display_char_buffer_pkg.sv | 31 +++
 rtl/display_write_fifo.sv | 50 +++++
 rtl/display_char_buffer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/display_char_buffer_pkg.sv
// Shared display constants, FSM encoding and write-queue payload for the character buffer.
package display_char_buffer_pkg;

  localparam int unsigned COLS               = 80;
  localparam int unsigned ROWS               = 30;
  localparam int unsigned CELLS              = COLS * ROWS;
  localparam int unsigned POS_W              = 12;
  localparam int unsigned CHAR_W             = 7;
  localparam int unsigned ENTRY_W            = POS_W + CHAR_W;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  localparam logic [CHAR_W-1:0] SPACE_CHAR = 7'h20;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Source of the scan data returned one cycle after a request
  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_RAM   = 2'd1,
    SRC_SPACE = 2'd2
  } scan_src_e;

  typedef struct packed {
    logic [POS_W-1:0]  position;
    logic [CHAR_W-1:0] char_code;
  } wr_entry_t;

endpackage

// File: rtl/display_write_fifo.sv
// Small write queue; a push into a full queue is accepted when a pop happens in the same cycle.
module display_write_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/display_char_buffer.sv
// 80x30 character frame store: queued writes, scan-priority single-port RAM.
// Optional post-reset space sweep enabled by defining DISPLAY_CLEAR_ON_RESET_EN.
module display_char_buffer
  import display_char_buffer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buffer_write_enable,
  input  logic [POS_W-1:0]  position,
  input  logic [CHAR_W-1:0] char_code,
  input  logic              scan_req,
  input  logic [POS_W-1:0]  scan_addr,
  output logic              scan_valid,
  output logic [CHAR_W-1:0] scan_char,
  output logic              overflow,
  output logic              busy
);

  localparam logic [POS_W-1:0] CELLS_LIM = POS_W'(CELLS);
  localparam logic [POS_W-1:0] LAST_CELL = POS_W'(CELLS - 1);
`ifdef DISPLAY_CLEAR_ON_RESET_EN
  localparam state_e RESET_STATE = CLEAR;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e            state_q;
  state_e            state_d;
  logic [POS_W-1:0]  clear_addr;
  logic              clear_step;
  scan_src_e         scan_src_d;
  scan_src_e         scan_src_q;

  wr_entry_t         fifo_din;
  wr_entry_t         fifo_dout;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic              wr_in_range;

  logic [CHAR_W-1:0] ram [CELLS];
  logic              ram_we;
  logic              ram_re;
  logic [POS_W-1:0]  ram_addr;
  logic [CHAR_W-1:0] ram_wdata;
  logic [CHAR_W-1:0] ram_rdata;

  assign wr_in_range = (position < CELLS_LIM);
  assign fifo_push   = buffer_write_enable && wr_in_range;
  assign fifo_din    = '{position: position, char_code: char_code};

  display_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Arbiter and next state: scan first, then queued writes, then the clear sweep
  always_comb begin
    state_d    = state_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = scan_addr;
    ram_wdata  = SPACE_CHAR;
    fifo_pop   = 1'b0;
    clear_step = 1'b0;
    scan_src_d = SRC_ZERO;
    if (scan_req) begin
      if (scan_addr >= CELLS_LIM) begin
        scan_src_d = SRC_ZERO;
      end else if (state_q == CLEAR) begin
        scan_src_d = SRC_SPACE;
      end else begin
        scan_src_d = SRC_RAM;
        ram_re     = 1'b1;
      end
    end else if (state_q == RUN && !fifo_empty) begin
      fifo_pop  = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = fifo_dout.position;
      ram_wdata = fifo_dout.char_code;
    end else if (state_q == CLEAR) begin
      clear_step = 1'b1;
      ram_we     = 1'b1;
      ram_addr   = clear_addr;
      if (clear_addr == LAST_CELL) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      clear_addr <= '0;
      scan_valid <= 1'b0;
      scan_src_q <= SRC_ZERO;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_valid <= scan_req;
      scan_src_q <= scan_src_d;
      if (clear_step) clear_addr <= clear_addr + POS_W'(1);
      if (buffer_write_enable && (!wr_in_range || (fifo_full && !fifo_pop))) overflow <= 1'b1;
    end
  end

  // Single-port RAM with synchronous read; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  always_comb begin
    scan_char = '0;
    case (scan_src_q)
      SRC_RAM:   scan_char = ram_rdata;
      SRC_SPACE: scan_char = SPACE_CHAR;
      default:   scan_char = '0;
    endcase
  end

`ifdef DISPLAY_CLEAR_ON_RESET_EN
  assign busy = (state_q == CLEAR);
`else
  assign busy = 1'b0;
`endif

endmodule
